// File: rtl/lfsr_gen.sv
// Run-time selectable Fibonacci/Galois LFSR with seed load, valid/ready output,
// all-zero lockup recovery and a saturating step counter with wrap detection.
module lfsr_gen #(
    parameter int unsigned WIDTH = 64,
    parameter logic [63:0] FTAPS = 64'h0000_0000_0000_0003,
    parameter logic [63:0] GTAPS = 64'hD800_0000_0000_0000,
    parameter logic [63:0] SEED  = 64'h0000_0000_0000_0202,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup,
    output logic             seq_wrap,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [WIDTH-1:0] SEED_W  = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] FTAPS_W = FTAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] GTAPS_W = GTAPS[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic             advance;

    // Candidate successor words for both polynomial forms
    always_comb begin
        fib_next  = {^(state_q & FTAPS_W), state_q[WIDTH-1:1]};
        gal_next  = (state_q >> 1) ^ ({WIDTH{state_q[0]}} & GTAPS_W);
        step_next = mode_q ? gal_next : fib_next;
        advance   = en && valid_q && out_ready && !load;
    end

    // Next-state: load beats everything, en gates both stepping and recovery
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        seed_d   = seed_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;

        if (load) begin
            fsm_d  = RUN;
            mode_d = mode;
            cnt_d  = '0;
            if (seed_in != '0) begin
                state_d = seed_in;
                seed_d  = seed_in;
            end else begin
                state_d  = SEED_W;
                seed_d   = SEED_W;
                lockup_d = 1'b1;
            end
        end else if (en) begin
            unique case (fsm_q)
                RUN: begin
                    if (state_q == '0) begin
                        fsm_d = RECOVER;
                    end else if (advance) begin
                        state_d = step_next;
                        wrap_d  = (step_next == seed_q);
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RECOVER: begin
                    fsm_d    = RUN;
                    state_d  = SEED_W;
                    seed_d   = SEED_W;
                    cnt_d    = '0;
                    lockup_d = 1'b1;
                end
                default: fsm_d = RUN;
            endcase
        end

        valid_d = (fsm_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q    <= RUN;
            state_q  <= SEED_W;
            seed_q   <= SEED_W;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b1;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            seed_q   <= seed_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out       = state_q;
    assign out_valid = valid_q;
    assign lockup    = lockup_q;
    assign seq_wrap  = wrap_q;
    assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a 16-bit instance checked against a scoreboard,
// a 4-bit instance for period/wrap/saturation, and a zero-tap instance for recovery.
module tb_lfsr_gen;

    localparam logic [15:0] FT16   = 16'h0003;
    localparam logic [15:0] GT16   = 16'hB400;
    localparam logic [15:0] SEED16 = 16'h0202;

    typedef struct packed {
        logic [15:0] out;
        logic [31:0] cnt;
        logic        lockup;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;

    logic        load16 = 1'b0, mode16 = 1'b0, rdy16 = 1'b0;
    logic [15:0] seed16 = '0;
    logic [15:0] out16;
    logic        vld16, lock16, wrap16;
    logic [31:0] cnt16;

    logic        load4 = 1'b0, rdy4 = 1'b0;
    logic [3:0]  seed4 = '0;
    logic [3:0]  out4;
    logic        vld4, lock4, wrap4;
    logic [3:0]  cnt4;

    logic        rdyb = 1'b0;
    logic [3:0]  outb;
    logic        vldb, lockb, wrapb;
    logic [31:0] cntb;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t        sb[$];
    logic [15:0] m16, mseed16;
    logic        mmode16;
    logic [31:0] mcnt16;
    logic [3:0]  m4;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(16), .FTAPS(64'h3), .GTAPS(64'hB400), .SEED(64'h0202), .CNT_W(32)) dut16 (
        .clk(clk), .rst(rst), .en(en), .load(load16), .seed_in(seed16), .mode(mode16),
        .out(out16), .out_valid(vld16), .out_ready(rdy16), .lockup(lock16),
        .seq_wrap(wrap16), .step_cnt(cnt16)
    );

    lfsr_gen #(.WIDTH(4), .FTAPS(64'h3), .GTAPS(64'h9), .SEED(64'h1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .load(load4), .seed_in(seed4), .mode(1'b0),
        .out(out4), .out_valid(vld4), .out_ready(rdy4), .lockup(lock4),
        .seq_wrap(wrap4), .step_cnt(cnt4)
    );

    // Zero taps drain the state to all-zero, forcing the recovery path
    lfsr_gen #(.WIDTH(4), .FTAPS(64'h0), .GTAPS(64'h9), .SEED(64'h1), .CNT_W(32)) dutb (
        .clk(clk), .rst(rst), .en(en), .load(1'b0), .seed_in(4'h0), .mode(1'b0),
        .out(outb), .out_valid(vldb), .out_ready(rdyb), .lockup(lockb),
        .seq_wrap(wrapb), .step_cnt(cntb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] nxt16(input logic [15:0] s, input logic md);
        logic        fb;
        logic [15:0] r;
        fb = 1'b0;
        r  = {1'b0, s[15:1]};
        if (!md) begin
            for (int i = 0; i < 16; i++) begin
                if (FT16[i]) fb = fb ^ s[i];
            end
            r[15] = fb;
        end else if (s[0]) begin
            r = r ^ GT16;
        end
        return r;
    endfunction

    function automatic logic [3:0] nxt4(input logic [3:0] s);
        return {s[0] ^ s[1], s[3:1]};
    endfunction

    // One clock of the 16-bit instance: predict, push, clock, pop, compare
    task automatic cyc16(input logic ld, input logic [15:0] sd, input logic md, input logic rdy,
                         input string tag);
        exp_t        e;
        logic [15:0] nx;
        load16 = ld;
        seed16 = sd;
        mode16 = md;
        rdy16  = rdy;
        e.lockup = 1'b0;
        e.wrap   = 1'b0;
        if (ld) begin
            mcnt16  = '0;
            mmode16 = md;
            if (sd != '0) begin
                m16 = sd;
            end else begin
                m16      = SEED16;
                e.lockup = 1'b1;
            end
            mseed16 = m16;
        end else if (en && rdy) begin
            nx     = nxt16(m16, mmode16);
            e.wrap = (nx == mseed16);
            m16    = nx;
            if (mcnt16 != '1) mcnt16 = mcnt16 + 32'd1;
        end
        e.out = m16;
        e.cnt = mcnt16;
        sb.push_back(e);
        @(posedge clk);
        #1;
        load16 = 1'b0;
        e = sb.pop_front();
        check({tag, ".out"},    64'(out16),  64'(e.out));
        check({tag, ".cnt"},    64'(cnt16),  64'(e.cnt));
        check({tag, ".lockup"}, 64'(lock16), 64'(e.lockup));
        check({tag, ".wrap"},   64'(wrap16), 64'(e.wrap));
        check({tag, ".valid"},  64'(vld16),  64'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        m16 = SEED16; mseed16 = SEED16; mmode16 = 1'b0; mcnt16 = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.out",    64'(out16),  64'(SEED16));
        check("rst.valid",  64'(vld16),  64'(1'b1));
        check("rst.lockup", 64'(lock16), 64'(1'b0));
        check("rst.wrap",   64'(wrap16), 64'(1'b0));
        check("rst.cnt",    64'(cnt16),  64'(0));
        check("rst.out4",   64'(out4),   64'(4'h1));
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle.out", 64'(out16), 64'(SEED16));

        // Fibonacci stream
        repeat (2) cyc16(1'b0, 16'h0, 1'b0, 1'b1, "fib");
        check("fib.word2", 64'(out16), 64'(16'hC080));
        check("fib.cnt2",  64'(cnt16), 64'(2));

        // Backpressure, then resume
        repeat (5) cyc16(1'b0, 16'h0, 1'b0, 1'b0, "bp");
        repeat (3) cyc16(1'b0, 16'h0, 1'b0, 1'b1, "resume");

        // Global enable low, mode toggled without load
        en = 1'b0;
        repeat (2) cyc16(1'b0, 16'h0, 1'b1, 1'b1, "en0");
        en = 1'b1;

        // Galois load coincident with handshake: load wins
        cyc16(1'b1, 16'h0001, 1'b1, 1'b1, "gload");
        check("gload.const", 64'(out16), 64'(16'h0001));
        repeat (2) cyc16(1'b0, 16'h0, 1'b0, 1'b1, "gal");
        check("gal.const", 64'(out16), 64'(16'h5A00));

        // Zero seed substitutes SEED and flags lockup
        cyc16(1'b1, 16'h0000, 1'b0, 1'b0, "zload");
        check("zload.const", 64'(out16), 64'(SEED16));
        repeat (2) cyc16(1'b0, 16'h0, 1'b0, 1'b1, "zrun");

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        check("arst.out",   64'(out16), 64'(SEED16));
        check("arst.cnt",   64'(cnt16), 64'(0));
        check("arst.valid", 64'(vld16), 64'(1'b1));
        rdy16 = 1'b0;
        m16 = SEED16; mseed16 = SEED16; mmode16 = 1'b0; mcnt16 = '0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        cyc16(1'b0, 16'h0, 1'b0, 1'b1, "post");
        check("post.const", 64'(out16), 64'(16'h8101));
        rdy16 = 1'b0;

        // Recovery from an all-zero state
        rdyb = 1'b1;
        @(posedge clk); #1;
        check("rec.zero",   64'(outb),  64'(4'h0));
        check("rec.cnt1",   64'(cntb),  64'(1));
        @(posedge clk); #1;
        check("rec.valid0", 64'(vldb),  64'(1'b0));
        check("rec.hold",   64'(cntb),  64'(1));
        check("rec.lock0",  64'(lockb), 64'(1'b0));
        @(posedge clk); #1;
        check("rec.seed",   64'(outb),  64'(4'h1));
        check("rec.valid1", 64'(vldb),  64'(1'b1));
        check("rec.lock1",  64'(lockb), 64'(1'b1));
        check("rec.cnt0",   64'(cntb),  64'(0));
        @(posedge clk); #1;
        check("rec.lockoff", 64'(lockb), 64'(1'b0));
        check("rec.again",   64'(outb),  64'(4'h0));
        rdyb = 1'b0;

        // 4-bit period, wrap pulses and counter saturation
        load4 = 1'b1; seed4 = 4'h1; rdy4 = 1'b1;
        @(posedge clk); #1;
        load4 = 1'b0;
        m4 = 4'h1;
        check("p4.load", 64'(out4), 64'(4'h1));
        check("p4.cnt0", 64'(cnt4), 64'(0));
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            m4 = nxt4(m4);
            check("p4.out",  64'(out4),  64'(m4));
            check("p4.wrap", 64'(wrap4), 64'((i == 15) || (i == 30)));
            check("p4.cnt",  64'(cnt4),  64'((i < 15) ? i : 15));
            if (i == 15) check("p4.period", 64'(out4), 64'(4'h1));
        end
        rdy4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random sequence generator and the successor to the fixed 64-bit Fibonacci LFSR. It supports a configurable width and tap masks, and a Fibonacci or Galois mode selected at run time. It also provides seed loading, a valid/ready output handshake, all-zero lockup recovery, and a period counter with wrap detection. It feeds PRBS stimulus and scrambler keys to downstream datapath blocks.

## Interface
- WIDTH, 64: state and output width; legal range 4..64.
- FTAPS, 64'h0000_0000_0000_0003: Fibonacci feedback mask. The feedback bit is the XOR of state bits where the mask is 1.
- GTAPS, 64'hD800_0000_0000_0000: Galois toggle mask, applied when the shifted-out LSB is 1.
- SEED, 64'h0000_0000_0000_0202: reset seed. It also substitutes for any zero seed. Must be nonzero.
- CNT_W, 32: width of the step counter.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- en  in  1  global advance enable.
- load  in  1  load seed_in and mode this cycle.
- seed_in  in  WIDTH  seed to load.
- mode  in  1  0 = Fibonacci, 1 = Galois. Sampled only on load.
- out  out  WIDTH  current LFSR state.
- out_valid  out  1  out holds a valid word.
- out_ready  in  1  consumer accepts out.
- lockup  out  1  one-cycle pulse: zero state detected or zero seed substituted.
- seq_wrap  out  1  one-cycle pulse: the sequence has returned to the active seed.
- step_cnt  out  CNT_W  accepted advances since the last load or reset; saturates at all-ones.

## Operation
- Internal registers:
  - state[WIDTH-1:0]
  - mode_q: latched mode
  - seed_q: active seed, used for wrap compare
  - step_cnt
  - FSM: RUN and RECOVER
- Fibonacci next state: next = {^(state & FTAPS[WIDTH-1:0]), state[WIDTH-1:1]}.
- Galois next state: next = (state >> 1) ^ ({WIDTH{state[0]}} & GTAPS[WIDTH-1:0]).
- Advance condition: en && out_valid && out_ready && !load. On advance:
  - state <= next.
  - step_cnt increments, saturating at all-ones.
  - seq_wrap pulses in the same cycle the register update is committed, if next == seed_q.
- load has priority over advance, regardless of en or out_ready. On load:
  - mode_q <= mode.
  - step_cnt <= 0.
  - If seed_in != 0: state <= seed_in and seed_q <= seed_in.
  - If seed_in == 0: state <= SEED, seed_q <= SEED, and lockup pulses.
- FSM:
  - RUN: out_valid=1.
  - RUN -> RECOVER: taken if state == 0 while not loading. This is a defensive path, e.g. after a bad tap choice or an upset.
  - RECOVER: out_valid=0 for exactly one cycle. state <= SEED, seed_q <= SEED, step_cnt <= 0, lockup pulses, then return to RUN.
  - A load in RECOVER is honoured and returns the FSM to RUN.
- en=0 freezes state, step_cnt and FSM. out_valid is unaffected, so out holds stable under backpressure.
- Words are never dropped: out changes only on an accepted advance, a load, or recovery.

## Timing
- Reset values:
  - state=SEED[WIDTH-1:0], seed_q=SEED, mode_q=0, FSM=RUN.
  - out=SEED, out_valid=1, lockup=0, seq_wrap=0, step_cnt=0.
- Reset asserts asynchronously and mid-operation returns all of the above immediately. Deassertion takes effect at the next rising clk.
- Latency:
  - An accepted handshake at edge N produces the next word on out after edge N, so one word per cycle at full throughput.
  - A load at edge N makes seed_in (or SEED) visible on out after edge N.
  - The first advance from a load needs a handshake at edge N+1 or later.
- lockup and seq_wrap are registered pulses, high for exactly the cycle after the triggering edge.
- step_cnt is registered and reflects advances committed up to the previous edge.
- Simultaneous load and out_ready: load wins, no advance occurs, and step_cnt reads 0 afterwards.
- A mode change without load has no effect.

## Test plan
- Reset, Fibonacci, WIDTH=16, FTAPS=16'h0003, SEED=16'h0202, out_ready=1, en=1 -> out sequence 0x0202, 0x8101, 0xC080; step_cnt=2 after two advances.
- Galois, WIDTH=16, GTAPS=16'hB400: load seed_in=0x0001 with mode=1 -> out 0x0001, 0xB400, 0x5A00.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> out and step_cnt frozen and out_valid=1. Release -> the sequence resumes with no skipped word.
- Load zero: seed_in=0 -> out=SEED (0x0202), lockup pulses one cycle, step_cnt=0.
- Period and wrap: WIDTH=4, FTAPS=4'h3, load seed 0x1, run continuously -> seq_wrap pulses after the 15th advance with step_cnt=15, and the pattern repeats every 15 advances.
- Async reset mid-stream, plus simultaneous load and handshake:
  - rst low between edges -> out=SEED with no clock edge needed.
  - load and out_ready high together -> out=seed_in and no advance.
